// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one Kogge-Stone adder among NUM_REQ
// requesters and returns results through a single-entry response register.

module configurable_kogge_stone_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  localparam int LVL = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] gk, pk, gn, pn;
  logic [DATA_WIDTH:0]   carry;

  // Parallel-prefix tree: after LVL levels, gk[i]/pk[i] span bits [i:0].
  always_comb begin
    gk = a & b;
    pk = a ^ b;
    gn = gk;
    pn = pk;
    for (int l = 0; l < LVL; l++) begin
      gn = gk;
      pn = pk;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
          pn[i] = pk[i] & pk[i - (1 << l)];
        end
      end
      gk = gn;
      pk = pn;
    end
  end

  // Carry-in enters as a generate below bit 0 of every prefix group.
  assign carry = {gk | (pk & {DATA_WIDTH{cin}}), cin};
  assign sum   = (a ^ b) ^ carry[DATA_WIDTH-1:0];
  assign cout  = carry[DATA_WIDTH];

endmodule

module adder_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_cout
);

  // Returns {found, index} of the first valid requester after 'last', wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [IDW-1:0]     last);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (v[idx]) r = {1'b1, idx[IDW-1:0]};
    end
    return r;
  endfunction

  logic                  run_q, run_d;
  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic                  rsp_cout_q, rsp_cout_d;

  logic                  gnt_found;
  logic [IDW-1:0]        gnt_idx;
  logic                  accept;
  logic                  hs;
  logic [DATA_WIDTH-1:0] add_a, add_b, add_sum;
  logic                  add_cin, add_cout;

  // run_q holds off grants until the first clock edge after reset release.
  always_comb begin
    {gnt_found, gnt_idx} = rr_pick(req_valid, last_grant_q);
    accept    = !rsp_valid_q || rsp_ready;
    hs        = gnt_found && accept && run_q;
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        add_a   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        add_b   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        add_cin = req_cin[i];
      end
    end
  end

  configurable_kogge_stone_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  // A drain without a new accept clears valid but leaves the payload stale.
  always_comb begin
    run_d        = 1'b1;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    if (hs) begin
      last_grant_d = gnt_idx;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_idx;
      rsp_sum_d    = add_sum;
      rsp_cout_d   = add_cout;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      run_q        <= run_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/sum width; SHALL be >=2.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; SHALL be >=2.
REQ-003 Localparam IDW = $clog2(NUM_REQ), requester-ID width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a  input  NUM_REQ*DATA_WIDTH  operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_b  input  NUM_REQ*DATA_WIDTH  operand B; same packing as req_a.
REQ-010 req_cin  input  NUM_REQ  per-requester carry-in.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  downstream accepts the response.
REQ-013 rsp_id  output  IDW  index of requester that owns the response.
REQ-014 rsp_sum  output  DATA_WIDTH  registered sum.
REQ-015 rsp_cout  output  1  registered carry-out.

Function
REQ-016 The block SHALL instantiate exactly one configurable_kogge_stone_adder (DATA_WIDTH passed through), shared by all requesters.
REQ-017 Adder inputs SHALL be muxed from the granted requester's req_a/req_b/req_cin; no other arithmetic path exists.
REQ-018 Single-entry response register; accept = !rsp_valid | rsp_ready.
REQ-019 Grant: round-robin over asserted req_valid bits, search starting at (last_grant+1) mod NUM_REQ, wrapping upward.
REQ-020 req_ready[i] SHALL be high iff i is the granted index and accept is high; grant is combinational from req_valid, last_grant, and accept.
REQ-021 A handshake (req_valid[i] & req_ready[i]) at edge k SHALL load rsp_sum/rsp_cout = {cout,sum} of a+b+cin, rsp_id = i, and rsp_valid = 1, visible after edge k (latency 1 cycle).
REQ-022 last_grant SHALL update to i only on a handshake; with no handshake it holds.
REQ-023 Response handshake (rsp_valid & rsp_ready) with no new request accepted SHALL clear rsp_valid next cycle; rsp_sum/rsp_id/rsp_cout hold their stale values.
REQ-024 Simultaneous response drain and new request accept SHALL load the new result, keeping rsp_valid high: sustained throughput of 1 op/cycle.
REQ-025 rsp_valid high & rsp_ready low: all req_ready low; rsp_sum, rsp_cout, rsp_id stable until drained.
REQ-026 A requester continuously asserting req_valid SHALL be granted within NUM_REQ accepted operations (no starvation).
REQ-027 Sum arithmetic modulo 2^DATA_WIDTH; overflow reported only via rsp_cout; operands treated as unsigned.
REQ-028 Requests whose req_valid drops before handshake are silently withdrawn; no state change.

Reset
REQ-029 rst_n low SHALL asynchronously force rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
REQ-030 While rst_n is low, req_ready SHALL be all zero; a response pending at reset is discarded.
REQ-031 Reset release SHALL take effect at the first clk rising edge after rst_n rises; no request is accepted in the same cycle rst_n rises.

Verification
REQ-032 After reset, req_valid=4'b0001, A=0xFFFFFFFF, B=0x00000001, cin=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x00000000, rsp_cout=1.
REQ-033 All four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,... on consecutive cycles, one response per cycle.
REQ-034 rsp_ready=0 with response pending, req_valid=4'b1111 for 5 cycles -> req_ready=0, rsp_sum/rsp_id unchanged; on rsp_ready=1 the next grant goes to last_grant+1.
REQ-035 Requester 2 valid only, A=0x12345678, B=0x0F0F0F0F, cin=1 -> rsp_id=2, rsp_sum=0x21436588, rsp_cout=0.
REQ-036 rst_n pulsed low asynchronously mid-stream with rsp_valid=1 -> rsp_valid, rsp_sum, rsp_cout, rsp_id =0 immediately, before the next clk edge; first post-reset grant goes to requester 0.
REQ-037 Random stimulus against a scoreboard: every accepted request yields exactly one response with correct {cout,sum} and id, in acceptance order.
